// File: rtl/tick_scheduler_pkg.sv
// Shared types, defaults and the round-robin pick helper for tick_scheduler.
package tick_scheduler_pkg;

    localparam int DEF_NUM_CH       = 4;
    localparam int DEF_PERIOD_WIDTH = 16;
    localparam int MAX_CH           = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } sched_state_e;

    // Request bits above the real channel count must be zero; the scan then
    // wraps modulo MAX_CH and still returns the first index at or after ptr.
    function automatic logic [3:0] rr_pick(input logic [MAX_CH-1:0] req,
                                           input logic [3:0] ptr);
        logic [3:0] idx;
        rr_pick = ptr;
        for (int k = MAX_CH - 1; k >= 0; k--) begin
            idx = ptr + 4'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requesting index at or after ptr.
module rr_arbiter
    import tick_scheduler_pkg::*;
#(
    parameter int  N  = DEF_NUM_CH,
    localparam int CW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    output logic [CW-1:0] grant,
    output logic          any
);

    assign grant = CW'(rr_pick(MAX_CH'(req), 4'(ptr)));
    assign any   = |req;

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel periodic event scheduler with round-robin event stream.
// Optional sticky overrun flags: define TICK_SCHEDULER_OVERRUN_EN.
module tick_scheduler
    import tick_scheduler_pkg::*;
#(
    parameter int  NUM_CH       = DEF_NUM_CH,
    parameter int  PERIOD_WIDTH = DEF_PERIOD_WIDTH,
    localparam int CH_WIDTH     = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick_in,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [CH_WIDTH-1:0]     cfg_ch,
    input  logic [PERIOD_WIDTH-1:0] cfg_period,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [CH_WIDTH-1:0]     evt_ch,
    output logic [NUM_CH-1:0]       active,
    output sched_state_e            state_dbg
`ifdef TICK_SCHEDULER_OVERRUN_EN
   ,output logic [NUM_CH-1:0]       overrun,
    input  logic                    overrun_clr
`endif
);

    // Both streams: a transfer happens on a clk edge where valid && ready;
    // the producer holds its payload stable while valid && !ready.

    localparam logic [PERIOD_WIDTH-1:0] ONE    = PERIOD_WIDTH'(1);
    localparam logic [CH_WIDTH-1:0]     LAST   = CH_WIDTH'(NUM_CH - 1);

    logic [PERIOD_WIDTH-1:0] period  [NUM_CH];
    logic [PERIOD_WIDTH-1:0] counter [NUM_CH];
    logic [NUM_CH-1:0]       pending;
    logic                    cfg_busy;
    sched_state_e            state, state_nx;
    logic [CH_WIDTH-1:0]     evt_ch_nx;
    logic [CH_WIDTH-1:0]     rr_ptr, rr_ptr_nx;

    logic                    cfg_fire;
    logic [NUM_CH-1:0]       cfg_mask;
    logic [NUM_CH-1:0]       hs_mask;
    logic [NUM_CH-1:0]       expire;
    logic                    handshake;
    logic [CH_WIDTH-1:0]     ptr_after;
    logic [NUM_CH-1:0]       arb_req;
    logic [CH_WIDTH-1:0]     arb_ptr;
    logic [CH_WIDTH-1:0]     arb_grant;
    logic                    arb_any;

    assign cfg_ready = ~cfg_busy;
    assign evt_valid = (state == OFFER);
    assign state_dbg = state;
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign handshake = evt_valid && evt_ready;
    assign ptr_after = (evt_ch == LAST) ? '0 : evt_ch + CH_WIDTH'(1);

    always_comb begin
        cfg_mask = '0;
        hs_mask  = '0;
        if (cfg_fire && ({1'b0, cfg_ch} < (CH_WIDTH + 1)'(NUM_CH)))
            cfg_mask = NUM_CH'(1) << cfg_ch;
        if (handshake)
            hs_mask = NUM_CH'(1) << evt_ch;
        for (int i = 0; i < NUM_CH; i++) begin
            active[i] = (period[i] != '0);
            expire[i] = tick_in && active[i] && (counter[i] == ONE);
        end
    end

    // A channel being reconfigured this edge is never the next offer.
    always_comb begin
        if (state == OFFER) begin
            arb_req = pending & ~hs_mask & ~cfg_mask;
            arb_ptr = ptr_after;
        end else begin
            arb_req = pending & ~cfg_mask;
            arb_ptr = rr_ptr;
        end
    end

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .req   (arb_req),
        .ptr   (arb_ptr),
        .grant (arb_grant),
        .any   (arb_any)
    );

    always_comb begin
        state_nx  = state;
        evt_ch_nx = evt_ch;
        rr_ptr_nx = rr_ptr;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    evt_ch_nx = arb_grant;
                    state_nx  = OFFER;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    rr_ptr_nx = ptr_after;
                    if (arb_any) evt_ch_nx = arb_grant;
                    else         state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            evt_ch <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nx;
            evt_ch <= evt_ch_nx;
            rr_ptr <= rr_ptr_nx;
        end
    end

    // Config beats the tick on its channel; a new expiry beats the handshake clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_busy <= 1'b0;
            pending  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                period[i]  <= '0;
                counter[i] <= '0;
            end
        end else begin
            cfg_busy <= cfg_fire;
            pending  <= (expire | (pending & ~hs_mask)) & ~cfg_mask;
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_mask[i]) begin
                    period[i]  <= cfg_period;
                    counter[i] <= cfg_period;
                end else if (tick_in && active[i]) begin
                    counter[i] <= expire[i] ? period[i] : counter[i] - ONE;
                end
            end
        end
    end

`ifdef TICK_SCHEDULER_OVERRUN_EN
    logic [NUM_CH-1:0] ovr_set;
    assign ovr_set = expire & pending & ~hs_mask & ~cfg_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overrun <= '0;
        else        overrun <= ovr_set | (overrun & ~cfg_mask & {NUM_CH{~overrun_clr}});
    end
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler; follows TICK_SCHEDULER_OVERRUN_EN if defined.
module tb_tick_scheduler;
    import tick_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_in = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_ch = '0;
    logic [15:0] cfg_period = '0;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [1:0]  evt_ch;
    logic [3:0]  active;
    sched_state_e state_dbg;

    // Second instance with a non-power-of-two channel count sees only
    // out-of-range writes (cfg_ch=5) and must stay idle throughout.
    logic [2:0]  cfg_ch5 = 3'd5;
    logic        cfg_ready5;
    logic        evt_valid5;
    logic [2:0]  evt_ch5;
    logic [4:0]  active5;
    sched_state_e state_dbg5;

`ifdef TICK_SCHEDULER_OVERRUN_EN
    logic [3:0]  overrun;
    logic [4:0]  overrun5;
    logic        overrun_clr = 1'b0;
`endif

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    tick_scheduler #(.NUM_CH(4), .PERIOD_WIDTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .tick_in(tick_in),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch),
        .active(active), .state_dbg(state_dbg)
`ifdef TICK_SCHEDULER_OVERRUN_EN
       ,.overrun(overrun), .overrun_clr(overrun_clr)
`endif
    );

    tick_scheduler #(.NUM_CH(5), .PERIOD_WIDTH(16)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .tick_in(tick_in),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready5), .cfg_ch(cfg_ch5), .cfg_period(cfg_period),
        .evt_valid(evt_valid5), .evt_ready(evt_ready), .evt_ch(evt_ch5),
        .active(active5), .state_dbg(state_dbg5)
`ifdef TICK_SCHEDULER_OVERRUN_EN
       ,.overrun(overrun5), .overrun_clr(overrun_clr)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        tick_in   = 1'b0;
        cfg_valid = 1'b0;
        evt_ready = 1'b0;
        #12;
        rst_n = 1'b1;
        step();
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [15:0] p);
        cfg_valid  = 1'b1;
        cfg_ch     = ch;
        cfg_period = p;
        step();
        cfg_valid = 1'b0;
        check("cfg_ready_low", 32'(cfg_ready), 32'd0);
        check("cfg_ready5_low", 32'(cfg_ready5), 32'd0);
        step();
        check("cfg_ready_back", 32'(cfg_ready), 32'd1);
    endtask

    task automatic expect_evt(input string tag, input logic v, input logic [1:0] ch);
        check(tag, 32'(evt_valid), 32'(v));
        if (v) check({tag, "_ch"}, 32'(evt_ch), 32'(ch));
    endtask

    initial begin
        // Reset values
        do_reset();
        check("rst_evt_valid", 32'(evt_valid), 32'd0);
        check("rst_evt_ch", 32'(evt_ch), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rst_active", 32'(active), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));

        // ch0 period 3, ten ticks four clocks apart: events after ticks 3, 6, 9
        evt_ready = 1'b1;
        cfg_write(2'd0, 16'd3);
        check("t1_active", 32'(active), 32'b0001);
        for (int t = 1; t <= 10; t++) begin
            tick_in = 1'b1;
            step();
            tick_in = 1'b0;
            expect_evt("t1_edge1", 1'b0, 2'd0);
            step();
            expect_evt("t1_edge2", (t % 3) == 0, 2'd0);
            step();
            expect_evt("t1_edge3", 1'b0, 2'd0);
            step();
        end

        // Three channels expire together: 0,1,2 back-to-back, two rounds
        do_reset();
        evt_ready = 1'b1;
        cfg_write(2'd0, 16'd2);
        cfg_write(2'd1, 16'd2);
        cfg_write(2'd2, 16'd2);
        check("t2_active", 32'(active), 32'b0111);
        for (int r = 0; r < 2; r++) begin
            tick_in = 1'b1;
            step();
            step();
            tick_in = 1'b0;
            expect_evt("t2_none", 1'b0, 2'd0);
            step();
            expect_evt("t2_first", 1'b1, 2'd0);
            step();
            expect_evt("t2_second", 1'b1, 2'd1);
            step();
            expect_evt("t2_third", 1'b1, 2'd2);
            step();
            expect_evt("t2_drain", 1'b0, 2'd0);
        end

        // Stalled offer on ch1 with a merged re-expiry during the stall
        do_reset();
        cfg_write(2'd1, 16'd2);
        tick_in = 1'b1;
        step();
        step();
        tick_in = 1'b0;
        step();
        expect_evt("t3_offer", 1'b1, 2'd1);
        for (int i = 0; i < 5; i++) begin
            tick_in = (i < 2);
            step();
            expect_evt("t3_stall", 1'b1, 2'd1);
        end
        tick_in = 1'b0;
`ifdef TICK_SCHEDULER_OVERRUN_EN
        check("t3_overrun", 32'(overrun), 32'b0010);
`endif
        evt_ready = 1'b1;
        step();
        expect_evt("t3_taken", 1'b0, 2'd0);
        step();
        expect_evt("t3_merged", 1'b0, 2'd0);
`ifdef TICK_SCHEDULER_OVERRUN_EN
        check("t3_overrun_hold", 32'(overrun), 32'b0010);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        check("t3_overrun_clr", 32'(overrun), 32'd0);
`endif

        // Config write and tick on the same edge: counter loads 5, not 4
        do_reset();
        evt_ready = 1'b1;
        cfg_write(2'd0, 16'd3);
        tick_in = 1'b1;
        step();
        tick_in    = 1'b0;
        cfg_valid  = 1'b1;
        cfg_ch     = 2'd0;
        cfg_period = 16'd5;
        tick_in    = 1'b1;
        step();
        cfg_valid = 1'b0;
        tick_in   = 1'b0;
        check("t4_cfg_ready_low", 32'(cfg_ready), 32'd0);
        step();
        check("t4_cfg_ready_back", 32'(cfg_ready), 32'd1);
        tick_in = 1'b1;
        repeat (4) step();
        tick_in = 1'b0;
        step();
        expect_evt("t4_after4", 1'b0, 2'd0);
        tick_in = 1'b1;
        step();
        tick_in = 1'b0;
        expect_evt("t4_tick5", 1'b0, 2'd0);
        step();
        expect_evt("t4_event", 1'b1, 2'd0);
        step();
        expect_evt("t4_done", 1'b0, 2'd0);

        // Disable ch2 while it is pending behind an offered ch0
        do_reset();
        cfg_write(2'd0, 16'd2);
        cfg_write(2'd2, 16'd2);
        tick_in = 1'b1;
        step();
        step();
        tick_in = 1'b0;
        step();
        expect_evt("t5_offer", 1'b1, 2'd0);
        cfg_write(2'd2, 16'd0);
        check("t5_active", 32'(active), 32'b0001);
        expect_evt("t5_still", 1'b1, 2'd0);
        evt_ready = 1'b1;
        step();
        expect_evt("t5_no_ch2", 1'b0, 2'd0);
        step();
        expect_evt("t5_idle", 1'b0, 2'd0);
        tick_in = 1'b1;
        step();
        step();
        tick_in = 1'b0;
        step();
        expect_evt("t5_ch0_again", 1'b1, 2'd0);
        step();
        expect_evt("t5_drain", 1'b0, 2'd0);
        check("t5_oob_active", 32'(active5), 32'd0);
        check("t5_oob_evt", 32'(evt_valid5), 32'd0);

        // Asynchronous reset in the middle of an offer
        do_reset();
        cfg_write(2'd1, 16'd1);
        tick_in = 1'b1;
        step();
        tick_in = 1'b0;
        step();
        expect_evt("t6_offer", 1'b1, 2'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_evt_valid_async", 32'(evt_valid), 32'd0);
        check("t6_cfg_ready_async", 32'(cfg_ready), 32'd1);
        check("t6_active_async", 32'(active), 32'd0);
        #3;
        rst_n = 1'b1;
        step();
        check("t6_active_after", 32'(active), 32'd0);
        expect_evt("t6_evt_after", 1'b0, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
